hb_fifo_arb: RTL and testbench
==============================

Name: hb_fifo_arb

Overview:
- Port-B write scheduler for the host bridge FIFO (1k x 16).
- Shares the single FIFO write port among bulk producers (GPS, RX, WF, MEM) using round-robin grants.
- Issues one source read strobe per cycle, tracks FIFO fill against capacity, and clips transfers that would overrun it.
- Sits in the hb_clk domain, between the producer blocks and the host FIFO port-B write/address logic.

Parameters:
- NREQ, 4, number of requesters; index 0 = GPS, 1 = RX, 2 = WF, 3 = MEM.
- AW, 10, FIFO word-address width; capacity = 2**AW words.
- CW, 10, per-request length field width (words).

Ports:
- hb_clk  in  1  system clock.
- hb_rst_n  in  1  asynchronous active-low reset.
- boot_busy  in  1  FIFO owned by boot loader; no grants while high.
- frame_rst  in  1  host reset pulse; starts a new frame, clears fill.
- req  in  NREQ  per-source request level; held until the matching done.
- req_len  in  NREQ*CW  word count per source; slice i = [i*CW +: CW]; sampled at grant.
- grant  out  NREQ  one-hot owner of the write port.
- src_rd  out  NREQ  one-hot read strobe to the owner; its data is valid in the same cycle.
- sel  out  2  owner index, drives the hb_din mux.
- hb_wr  out  1  FIFO port-B write enable; equals |src_rd.
- fill  out  AW+1  words written this frame (0..2**AW).
- done  out  NREQ  one-cycle completion pulse to the owner.
- ovfl  out  1  sticky flag: some transfer was clipped.
- ovfl_clr  in  1  clears ovfl.

Behaviour:
- Reset values: grant=0, src_rd=0, sel=0, hb_wr=0, fill=0, done=0, ovfl=0, rr_ptr=0, state=IDLE.
- All outputs are registered. hb_wr and sel are registered together with src_rd.
- States:
  - IDLE: if !boot_busy and |req, choose the first set req at or after rr_ptr, cyclic. Latch idx and len_eff. Set grant; go to GRANT.
  - GRANT: one setup cycle for the source. If len_eff == 0, go to DONE. Otherwise go to XFER.
  - XFER: assert src_rd[idx] and hb_wr every cycle. Decrement the remaining count and increment fill. After the last word, go to DONE.
  - DONE: pulse done[idx], clear grant, set rr_ptr = idx+1 mod NREQ, go to IDLE.
- Latency:
  - req high in IDLE at cycle t gives grant at t+1 and the first src_rd at t+2.
  - The last src_rd is at t+1+len_eff; done pulses at t+2+len_eff.
  - Minimum transfer cycle (len=0) is 3 clocks.
- Clipping: space = 2**AW - fill. len_eff = min(req_len[idx], space). If clipped, set ovfl in the GRANT cycle. With fill == 2**AW, len_eff = 0 but done still pulses.
- fill saturates at 2**AW and never wraps. Width is AW+1 so the full count is representable.
- frame_rst has highest priority in every state:
  - fill ← 0.
  - An active transfer is aborted: grant, src_rd and hb_wr drop the next cycle, no done pulse, return to IDLE.
  - rr_ptr is unchanged and ovfl is unchanged.
- boot_busy high:
  - Blocks new grants.
  - Aborts any transfer exactly like frame_rst, but fill is kept.
- ovfl set and ovfl_clr in the same cycle: set wins.
- req dropping mid-transfer is ignored; the transfer runs to len_eff.
- req_len is sampled only in IDLE; later changes have no effect.
- At most one src_rd bit is ever high; src_rd is a subset of grant.

Decomposition:
- Shared package/include (kiwi.vh):
  - Constants SRC_GPS=0, SRC_RX=1, SRC_WF=2, SRC_MEM=3.
  - State encodings ST_IDLE, ST_GRANT, ST_XFER, ST_DONE.
  - HB_FIFO_AW=10.
- One sub-module: rr_pick. Purely combinational round-robin priority encoder: inputs (req, rr_ptr), outputs (idx, valid). It is reused by future multi-source arbiters.

Test Plan:
1. Single request: req[1]=1, len=5, fill=0. Expect grant=0010 at t+1, src_rd[1] high for t+2..t+6 (5 pulses), sel=1, done[1] at t+7, fill=5.
2. Round-robin: all req high, each len=2, from reset. Expect grant order 0,1,2,3,0. Each gets 2 writes; fill=8 after the first four transfers.
3. Clipping: fill=1020, req[2] with len=10. Expect 4 writes, ovfl=1, done[2] pulses, fill=1024. Then req[3] with len=3: 0 writes, done after 3 cycles.
4. Abort: frame_rst during the 3rd word of a len=8 transfer from source 0. Expect src_rd low the next cycle, no done[0], fill=0, IDLE. Source 0 still requesting is regranted with a fresh len.
5. Boot gating: boot_busy=1 with req=1111. Expect no grant for 100 cycles. Deassert boot_busy: grant at rr_ptr within 1 cycle.
6. Reset mid-transfer: hb_rst_n low asynchronously. Expect all outputs 0 immediately. ovfl_clr together with a clip event leaves ovfl=1.

Source files
------------

// File: rtl/hb_fifo_arb_pkg.sv
// Shared constants and state encoding for the host-bridge FIFO port-B write scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hb_fifo_arb_pkg;

  // Host FIFO word-address width (1k x 16 FIFO).
  localparam int HB_FIFO_AW = 10;

  // Requester indices on the req/grant/src_rd/done vectors.
  localparam int SRC_GPS = 0;
  localparam int SRC_RX  = 1;
  localparam int SRC_WF  = 2;
  localparam int SRC_MEM = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } hb_arb_state_t;

endpackage

// File: rtl/hb_fifo_arb_rr_pick.sv
// Round-robin priority encoder: first set req at or after rr_ptr, wrapping cyclically.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is set.
// Ports: req (request levels), rr_ptr (highest-priority index), idx (chosen index), valid.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Walk the candidates from the lowest priority upwards so the highest
  // priority hit (closest to rr_ptr) is the last one written.
  always_comb begin : pick
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hb_fifo_arb.sv
// Port-B write scheduler: round-robin shares the host FIFO write port among bulk producers, clipping to free space.
// Latency: grant 1 clk after req seen in IDLE, first src_rd 1 clk later, done 1 clk after last src_rd.
// Backpressure: none on the FIFO side; producers wait on grant, boot_busy/frame_rst abort an active transfer.
// Ports: hb_clk/hb_rst_n; boot_busy, frame_rst, req, req_len, ovfl_clr in;
//        grant, src_rd, sel, hb_wr, fill, done, ovfl out (all registered).
module hb_fifo_arb
  import hb_fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int AW   = HB_FIFO_AW,
  parameter  int CW   = 10,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              hb_clk,
  input  logic              hb_rst_n,
  input  logic              boot_busy,
  input  logic              frame_rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   src_rd,
  output logic [IW-1:0]     sel,
  output logic              hb_wr,
  output logic [AW:0]       fill,
  output logic [NREQ-1:0]   done,
  output logic              ovfl,
  input  logic              ovfl_clr
);

  // Length arithmetic is wide enough for both req_len and the free-space count.
  localparam int          LW   = (CW > AW + 1) ? CW : AW + 1;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  hb_arb_state_t state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            clip_q, clip_d;
  logic [NREQ-1:0] grant_d, src_rd_d, done_d;
  logic [IW-1:0]   sel_d;
  logic            hb_wr_d, ovfl_d, ovfl_set;
  logic [AW:0]     fill_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [CW-1:0]   len_req;
  logic [LW-1:0]   len_w, space_w, len_eff;
  logic            clip_now;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Fill is stable while IDLE (no writes in flight), so the clip decision can
  // be made at grant time from the current count.
  assign len_req  = req_len[int'(pick_idx) * CW +: CW];
  assign len_w    = LW'(len_req);
  assign space_w  = LW'(FULL - fill);
  assign clip_now = (len_w > space_w);
  assign len_eff  = clip_now ? space_w : len_w;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    clip_d   = clip_q;
    grant_d  = grant;
    sel_d    = sel;
    src_rd_d = '0;
    hb_wr_d  = 1'b0;
    done_d   = '0;
    ovfl_set = 1'b0;

    // Count the word written this cycle; frame_rst discards it with the frame.
    if (frame_rst)                   fill_d = '0;
    else if (hb_wr && (fill != FULL)) fill_d = fill + 1'b1;
    else                             fill_d = fill;

    if (frame_rst || boot_busy) begin
      // Abort: drop ownership silently, no done pulse, keep rr_ptr.
      state_d = ST_IDLE;
      grant_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            idx_d             = pick_idx;
            rem_d             = len_eff;
            clip_d            = clip_now;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            sel_d             = pick_idx;
            state_d           = ST_GRANT;
          end
        end
        ST_GRANT: begin
          ovfl_set = clip_q;
          if (rem_q == '0) begin
            done_d[idx_q] = 1'b1;
            state_d       = ST_DONE;
          end else begin
            src_rd_d[idx_q] = 1'b1;
            hb_wr_d         = 1'b1;
            rem_d           = rem_q - 1'b1;
            state_d         = ST_XFER;
          end
        end
        ST_XFER: begin
          // rem_q counts words still to issue after the one on src_rd now.
          if (rem_q != '0) begin
            src_rd_d[idx_q] = 1'b1;
            hb_wr_d         = 1'b1;
            rem_d           = rem_q - 1'b1;
          end else begin
            done_d[idx_q] = 1'b1;
            state_d       = ST_DONE;
          end
        end
        ST_DONE: begin
          grant_d  = '0;
          rr_ptr_d = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A clip in the same cycle as a clear must stay visible.
    if (ovfl_set)      ovfl_d = 1'b1;
    else if (ovfl_clr) ovfl_d = 1'b0;
    else               ovfl_d = ovfl;
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      rem_q    <= '0;
      clip_q   <= 1'b0;
      grant    <= '0;
      src_rd   <= '0;
      sel      <= '0;
      hb_wr    <= 1'b0;
      fill     <= '0;
      done     <= '0;
      ovfl     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
      clip_q   <= clip_d;
      grant    <= grant_d;
      src_rd   <= src_rd_d;
      sel      <= sel_d;
      hb_wr    <= hb_wr_d;
      fill     <= fill_d;
      done     <= done_d;
      ovfl     <= ovfl_d;
    end
  end

endmodule

// File: tb/tb_hb_fifo_arb.sv
// Self-checking bench for hb_fifo_arb: directed steps plus randomized transactions,
// checked against a transaction-level model (fill, round-robin pointer, sticky overflow).
module tb_hb_fifo_arb;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int CW   = 10;
  localparam int CAP  = 1024;

  logic              hb_clk;
  logic              hb_rst_n;
  logic              boot_busy;
  logic              frame_rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   src_rd;
  logic [1:0]        sel;
  logic              hb_wr;
  logic [AW:0]       fill;
  logic [NREQ-1:0]   done;
  logic              ovfl;
  logic              ovfl_clr;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state.
  int m_fill = 0;
  int m_rr   = 0;
  bit m_ovfl = 0;

  hb_fifo_arb dut (
    .hb_clk    (hb_clk),
    .hb_rst_n  (hb_rst_n),
    .boot_busy (boot_busy),
    .frame_rst (frame_rst),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .src_rd    (src_rd),
    .sel       (sel),
    .hb_wr     (hb_wr),
    .fill      (fill),
    .done      (done),
    .ovfl      (ovfl),
    .ovfl_clr  (ovfl_clr)
  );

  initial hb_clk = 1'b0;
  always #5 hb_clk = ~hb_clk;

  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requesting source at or after the pointer, cyclic.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic set_len(input int s, input int l);
    req_len[s*CW +: CW] = CW'(l);
  endtask

  // One complete transaction from the currently driven req/req_len.
  // Returns one cycle after the done pulse, with the arbiter back in IDLE.
  task automatic xfer(input int exp_wait, input bit clr_req, input bit clr_at_grant);
    int src, lreq, len, w, k, nwr;
    bit clip, got_done;
    src  = model_pick(req, m_rr);
    lreq = int'(req_len[src*CW +: CW]);
    len  = (lreq < CAP - m_fill) ? lreq : CAP - m_fill;
    clip = (lreq > CAP - m_fill);
    w = 0;
    while (grant == '0 && w < 20) begin
      tick();
      w++;
    end
    chk("grant_latency", w, exp_wait);
    chk("grant_onehot", grant, 32'(1) << src);
    if (clr_at_grant) ovfl_clr = 1'b1;
    k = 0;
    nwr = 0;
    got_done = 0;
    while (!got_done && k < 1100) begin
      tick();
      ovfl_clr = 1'b0;
      k++;
      if (done != '0) got_done = 1;
      else if (src_rd != '0) begin
        nwr++;
        chk("beat_rd_wr_sel", {src_rd, hb_wr, sel}, {4'(1 << src), 1'b1, 2'(src)});
      end
    end
    chk("done_cycle", k, len + 1);
    chk("done_onehot", done, 32'(1) << src);
    chk("write_count", nwr, len);
    m_fill += len;
    if (clip) m_ovfl = 1;
    m_rr = (src + 1) % NREQ;
    chk("fill_after", fill, m_fill);
    chk("ovfl_after", ovfl, m_ovfl);
    if (clr_req) req[src] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    hb_rst_n  = 1'b0;
    boot_busy = 1'b0;
    frame_rst = 1'b0;
    ovfl_clr  = 1'b0;
    req       = '0;
    req_len   = '0;
    tick();
    tick();
    hb_rst_n = 1'b1;
    m_fill = 0;
    m_rr   = 0;
    m_ovfl = 0;
  endtask

  initial begin
    int n, bad;
    logic [NREQ-1:0] mask;

    // Reset values.
    do_reset();
    chk("reset_outputs", {grant, src_rd, sel, hb_wr, fill, done, ovfl}, '0);

    // Single request: RX, 5 words.
    req = 4'b0010;
    set_len(1, 5);
    xfer(1, 1, 0);

    // Round-robin from reset: all requesting, 2 words each, order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < NREQ; s++) set_len(s, 2);
    for (int i = 0; i < 5; i++) xfer(1, 0, 0);
    req = '0;

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      mask = 4'($urandom_range(1, 15));
      for (int s = 0; s < NREQ; s++) set_len(s, $urandom_range(0, 12));
      req = mask;
      xfer(1, 0, 0);
    end
    req = '0;

    // Clipping near full, with a coincident ovfl_clr that must lose.
    frame_rst = 1'b1;
    tick();
    frame_rst = 1'b0;
    m_fill = 0;
    chk("frame_rst_fill", fill, 0);
    req = 4'b0001;
    set_len(0, 1020);
    xfer(1, 1, 0);
    chk("ovfl_before_clip", ovfl, 0);
    req = 4'b0100;
    set_len(2, 10);
    xfer(1, 1, 1);
    req = 4'b1000;
    set_len(3, 3);
    xfer(1, 1, 0);
    ovfl_clr = 1'b1;
    tick();
    ovfl_clr = 1'b0;
    m_ovfl = 0;
    chk("ovfl_clear", ovfl, 0);

    // Abort: frame_rst on the 3rd word of an 8-word GPS transfer.
    frame_rst = 1'b1;
    tick();
    frame_rst = 1'b0;
    m_fill = 0;
    req = 4'b0001;
    set_len(0, 8);
    tick();
    chk("abort_grant", grant, 4'b0001);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (src_rd[0]) n++;
    end
    chk("abort_beats_seen", n, 3);
    frame_rst = 1'b1;
    tick();
    frame_rst = 1'b0;
    chk("abort_outputs", {grant, src_rd, hb_wr, done, fill}, '0);
    set_len(0, 4);
    xfer(1, 1, 0);

    // Boot gating.
    boot_busy = 1'b1;
    req = 4'b1111;
    for (int s = 0; s < NREQ; s++) set_len(s, 3);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (grant != '0 || src_rd != '0) bad++;
    end
    chk("boot_no_grant", bad, 0);
    boot_busy = 1'b0;
    tick();
    chk("boot_release_grant", grant, 32'(1) << m_rr);
    xfer(0, 0, 0);

    // Asynchronous reset in the middle of a transfer.
    tick();
    tick();
    #2;
    hb_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {grant, src_rd, sel, hb_wr, fill, done, ovfl}, '0);
    @(posedge hb_clk);
    #1;
    hb_rst_n = 1'b1;
    m_fill = 0;
    m_rr   = 0;
    m_ovfl = 0;
    xfer(1, 1, 0);
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
